// File: rtl/cam_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cam_pkg : shared types and constants for the CAM refill scheduler
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
package cam_pkg;

  localparam int CAM_PACKS      = 4;
  localparam int CAM_UPDATE_LAT = 2;

  typedef logic [CAM_PACKS-1:0][4:0] cam_key_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PROBE   = 3'd1,
    WRITE   = 3'd2,
    SETTLE1 = 3'd3,
    SETTLE2 = 3'd4,
    DONE    = 3'd5
  } cam_sched_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : grants the lowest requesting index >= ptr, wrapping around
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  always_comb begin
    logic [IW-1:0] w_idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    w_idx     = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = IW'((int'(ptr) + i) % N);
      if (!grant_any && req[w_idx]) begin
        grant_any    = 1'b1;
        grant[w_idx] = 1'b1;
        grant_idx    = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cam_refill_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cam_refill_sched : arbitrates key inserts, probes for duplicates, writes a
//                    victim CAM entry and guards it through its settle window
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module cam_refill_sched
  import cam_pkg::*;
#(
  parameter  int ENTRIES         = 8,
  parameter  int NREQ            = 2,
  parameter  int PACKS_OF_5_BITS = CAM_PACKS,
  localparam int KEY_W           = 5 * PACKS_OF_5_BITS,
  localparam int IDX_W           = $clog2(ENTRIES),
  localparam int RR_W            = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid_i,
  input  logic [NREQ-1:0][KEY_W-1:0] req_key_i,
  output logic [NREQ-1:0]            req_ready_o,
  input  logic                       flush_i,
  output logic [KEY_W-1:0]           probe_key_o,
  input  logic [ENTRIES-1:0]         cam_hit_i,
  output logic [ENTRIES-1:0]         upd_o,
  output logic [KEY_W-1:0]           upd_key_o,
  output logic [ENTRIES-1:0]         entry_valid_o,
  output logic [ENTRIES-1:0]         entry_busy_o,
  output logic                       done_o,
  output logic [IDX_W-1:0]           done_idx_o,
  output logic                       done_dup_o
);

  cam_sched_state_e   r_state;
  cam_sched_state_e   w_state_nxt;
  logic [RR_W-1:0]    r_rr_ptr;
  logic [IDX_W-1:0]   r_victim_ptr;
  logic [IDX_W-1:0]   r_idx;
  logic               r_from_ptr;
  logic               r_wr_flushed;
  logic [KEY_W-1:0]   r_key;
  logic [ENTRIES-1:0] r_valid;

  logic [NREQ-1:0]    w_grant;
  logic [RR_W-1:0]    w_grant_idx;
  logic               w_grant_any;
  logic [ENTRIES-1:0] w_busy;
  logic [ENTRIES-1:0] w_hit;
  logic [IDX_W-1:0]   w_hit_idx;
  logic               w_hit_any;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_free_any;
  logic [IDX_W-1:0]   w_victim;
  logic               w_in_write;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req       (req_valid_i),
    .ptr       (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .grant_any (w_grant_any)
  );

  assign w_in_write = (r_state == WRITE) || (r_state == SETTLE1) || (r_state == SETTLE2);
  assign w_busy     = w_in_write ? (ENTRIES'(1) << r_idx) : '0;
  assign w_hit      = cam_hit_i & r_valid & ~w_busy;

  // Lowest-index priority encoders for hits and free entries.
  always_comb begin
    w_hit_idx  = '0;
    w_hit_any  = 1'b0;
    w_free_idx = '0;
    w_free_any = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_hit_idx = IDX_W'(i);
        w_hit_any = 1'b1;
      end
      if (!r_valid[i]) begin
        w_free_idx = IDX_W'(i);
        w_free_any = 1'b1;
      end
    end
  end

  assign w_victim = w_free_any ? w_free_idx : r_victim_ptr;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant_any) w_state_nxt = PROBE;
      PROBE: begin
        if (flush_i)        w_state_nxt = PROBE;
        else if (w_hit_any) w_state_nxt = DONE;
        else                w_state_nxt = WRITE;
      end
      WRITE:   w_state_nxt = SETTLE1;
      SETTLE1: w_state_nxt = SETTLE2;
      SETTLE2: w_state_nxt = IDLE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o   = (r_state == IDLE) ? w_grant : '0;
    probe_key_o   = (r_state != IDLE) ? r_key : '0;
    upd_o         = (r_state == WRITE) ? (ENTRIES'(1) << r_idx) : '0;
    upd_key_o     = (r_state == WRITE) ? r_key : '0;
    entry_valid_o = r_valid;
    entry_busy_o  = w_busy;
    done_o        = (r_state == SETTLE2) || (r_state == DONE);
    done_idx_o    = done_o ? r_idx : '0;
    done_dup_o    = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_key    <= '0;
    end else if (r_state == IDLE && w_grant_any) begin
      r_key    <= req_key_i[w_grant_idx];
      r_rr_ptr <= (w_grant_idx == RR_W'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_from_ptr <= 1'b0;
    end else if (r_state == PROBE && !flush_i) begin
      r_idx      <= w_hit_any ? w_hit_idx : w_victim;
      r_from_ptr <= !w_hit_any && !w_free_any;
    end
  end

  // A flush that lands mid-write must keep the victim from going valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_flushed <= 1'b0;
    end else if (r_state == WRITE || r_state == SETTLE1) begin
      r_wr_flushed <= r_wr_flushed | flush_i;
    end else begin
      r_wr_flushed <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (flush_i) begin
      r_valid <= '0;
    end else if (r_state == PROBE && !w_hit_any) begin
      r_valid[w_victim] <= 1'b0;
    end else if (r_state == SETTLE1 && !r_wr_flushed) begin
      r_valid[r_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_victim_ptr <= '0;
    end else if (flush_i) begin
      r_victim_ptr <= '0;
    end else if (r_state == WRITE && r_from_ptr) begin
      r_victim_ptr <= r_victim_ptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cam_refill_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cam_refill_sched : directed vectors for the CAM refill scheduler
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module tb_cam_refill_sched;
  import cam_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0][19:0] req_key;
  logic [1:0]      req_ready;
  logic            flush;
  logic [19:0]     probe_key;
  logic [7:0]      cam_hit;
  logic [7:0]      upd;
  logic [19:0]     upd_key;
  logic [7:0]      entry_valid;
  logic [7:0]      entry_busy;
  logic            done;
  logic [2:0]      done_idx;
  logic            done_dup;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  cam_refill_sched #(.ENTRIES(8), .NREQ(2), .PACKS_OF_5_BITS(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid),
    .req_key_i     (req_key),
    .req_ready_o   (req_ready),
    .flush_i       (flush),
    .probe_key_o   (probe_key),
    .cam_hit_i     (cam_hit),
    .upd_o         (upd),
    .upd_key_o     (upd_key),
    .entry_valid_o (entry_valid),
    .entry_busy_o  (entry_busy),
    .done_o        (done),
    .done_idx_o    (done_idx),
    .done_dup_o    (done_dup)
  );

  // Behavioural CAM array: stores keys on upd, raw compare against probe_key.
  bit [19:0] mkey [8];
  bit [7:0]  mvalid;

  always @(posedge clk) begin
    for (int e = 0; e < 8; e++) begin
      if (upd[e]) begin
        mkey[e]   <= upd_key;
        mvalid[e] <= 1'b1;
      end
    end
  end

  always_comb begin
    cam_hit = '0;
    for (int e = 0; e < 8; e++) cam_hit[e] = mvalid[e] && (mkey[e] == probe_key);
  end

  typedef struct {
    logic [1:0]  valid;
    logic [19:0] k0;
    logic [19:0] k1;
    logic [1:0]  exp_ready;
    logic        exp_dup;
    logic [2:0]  exp_idx;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic reset_dut();
    req_valid = '0;
    flush     = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outputs", {req_ready, upd, entry_valid, entry_busy, done, done_dup}, '0);
    chk("rst_keys", {probe_key, upd_key}, '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Grant in IDLE, then wait a bounded number of cycles for done_o.
  task automatic run_row(input vec_t v, input string nm);
    int   n;
    bit   got;
    logic [7:0] upd_seen;
    @(negedge clk);
    req_valid  = v.valid;
    req_key[0] = v.k0;
    req_key[1] = v.k1;
    #1;
    chk({nm, "_ready"}, req_ready, v.exp_ready);
    upd_seen = '0;
    got      = 1'b0;
    n        = 0;
    while (!got && n < 10) begin
      @(negedge clk);
      req_valid = '0;
      n++;
      #1;
      upd_seen |= upd;
      if (done) begin
        got = 1'b1;
        chk({nm, "_idx"}, done_idx, v.exp_idx);
        chk({nm, "_dup"}, done_dup, v.exp_dup);
        chk({nm, "_lat"}, n, v.exp_dup ? 2 : 2 + CAM_UPDATE_LAT);
      end
    end
    if (!got) chk({nm, "_done_timeout"}, 0, 1);
    chk({nm, "_upd"}, upd_seen, v.exp_dup ? 8'h00 : (8'h01 << v.exp_idx));
  endtask

  initial begin
    int seen_done;

    tbl[0]  = '{2'b11, 20'h00A00, 20'h00B01, 2'b01, 1'b0, 3'd0};
    tbl[1]  = '{2'b11, 20'h00A02, 20'h00B01, 2'b10, 1'b0, 3'd1};
    tbl[2]  = '{2'b11, 20'h00A02, 20'h00B03, 2'b01, 1'b0, 3'd2};
    tbl[3]  = '{2'b11, 20'h00A04, 20'h00B03, 2'b10, 1'b0, 3'd3};
    tbl[4]  = '{2'b11, 20'h00A04, 20'h00B05, 2'b01, 1'b0, 3'd4};
    tbl[5]  = '{2'b11, 20'h00A06, 20'h00B05, 2'b10, 1'b0, 3'd5};
    tbl[6]  = '{2'b11, 20'h00A06, 20'h00B07, 2'b01, 1'b0, 3'd6};
    tbl[7]  = '{2'b11, 20'h00A08, 20'h00B07, 2'b10, 1'b0, 3'd7};
    tbl[8]  = '{2'b01, 20'h00A08, 20'h00000, 2'b01, 1'b0, 3'd0};
    tbl[9]  = '{2'b10, 20'h00000, 20'h00B09, 2'b10, 1'b0, 3'd1};
    tbl[10] = '{2'b01, 20'h00A0A, 20'h00000, 2'b01, 1'b0, 3'd2};
    tbl[11] = '{2'b10, 20'h00000, 20'h00B03, 2'b10, 1'b1, 3'd3};
    tbl[12] = '{2'b01, 20'h00A08, 20'h00000, 2'b01, 1'b1, 3'd0};
    tbl[13] = '{2'b11, 20'h00A04, 20'h00B05, 2'b10, 1'b1, 3'd5};

    req_key = '0;
    reset_dut();

    // First insert, cycle by cycle.
    @(negedge clk);
    req_valid  = 2'b01;
    req_key[0] = 20'h12345;
    #1;
    chk("t1_ready_c0", req_ready, 2'b01);
    chk("t1_probe_idle", probe_key, 20'h0);
    @(negedge clk); req_valid = '0; #1;
    chk("t1_probe_key_c1", probe_key, 20'h12345);
    chk("t1_no_upd_c1", upd, 8'h00);
    @(negedge clk); #1;
    chk("t1_upd_c2", upd, 8'h01);
    chk("t1_upd_key_c2", upd_key, 20'h12345);
    chk("t1_busy_c2", entry_busy, 8'h01);
    chk("t1_valid_c2", entry_valid, 8'h00);
    @(negedge clk); #1;
    chk("t1_busy_c3", entry_busy, 8'h01);
    chk("t1_upd_off_c3", upd, 8'h00);
    chk("t1_done_c3", done, 1'b0);
    @(negedge clk); #1;
    chk("t1_done_c4", {done, done_idx, done_dup}, {1'b1, 3'd0, 1'b0});
    chk("t1_busy_c4", entry_busy, 8'h01);
    chk("t1_valid_c4", entry_valid, 8'h01);
    @(negedge clk); #1;
    chk("t1_idle_c5", {done, entry_busy, entry_valid}, {1'b0, 8'h00, 8'h01});

    // Duplicate insert of the same key.
    @(negedge clk);
    req_valid  = 2'b01;
    req_key[0] = 20'h12345;
    #1;
    chk("t2_ready_c0", req_ready, 2'b01);
    @(negedge clk); req_valid = '0; #1;
    chk("t2_cam_hit_c1", cam_hit, 8'h01);
    chk("t2_done_early_c1", done, 1'b0);
    @(negedge clk); #1;
    chk("t2_done_c2", {done, done_idx, done_dup}, {1'b1, 3'd0, 1'b1});
    chk("t2_no_upd_c2", upd, 8'h00);
    @(negedge clk); #1;
    chk("t2_done_off_c3", done, 1'b0);

    // Round-robin alternation, fill, victim wrap and duplicates.
    reset_dut();
    for (int i = 0; i < 14; i++) begin
      run_row(tbl[i], $sformatf("row%0d", i));
      if (i == 7) chk("fill_all_valid", entry_valid, 8'hFF);
    end

    // Flush during SETTLE1 of entry 3.
    reset_dut();
    run_row('{2'b01, 20'h11111, 20'h0, 2'b01, 1'b0, 3'd0}, "t5_e0");
    run_row('{2'b01, 20'h22222, 20'h0, 2'b01, 1'b0, 3'd1}, "t5_e1");
    run_row('{2'b01, 20'h33333, 20'h0, 2'b01, 1'b0, 3'd2}, "t5_e2");
    @(negedge clk);
    req_valid  = 2'b01;
    req_key[0] = 20'h3C3C3;
    #1;
    chk("t5_ready", req_ready, 2'b01);
    @(negedge clk); req_valid = '0;
    @(negedge clk); #1;
    chk("t5_upd", upd, 8'h08);
    @(negedge clk); flush = 1'b1; #1;
    chk("t5_busy_s1", entry_busy, 8'h08);
    @(negedge clk); flush = 1'b0; #1;
    chk("t5_done", {done, done_idx, done_dup}, {1'b1, 3'd3, 1'b0});
    chk("t5_valid_s2", entry_valid, 8'h00);
    @(negedge clk); #1;
    chk("t5_valid_after", entry_valid, 8'h00);
    run_row('{2'b01, 20'h44444, 20'h0, 2'b01, 1'b0, 3'd0}, "t5_next");

    // Flush during PROBE discards the duplicate hit and re-probes.
    @(negedge clk);
    req_valid  = 2'b01;
    req_key[0] = 20'h44444;
    #1;
    chk("fp_ready", req_ready, 2'b01);
    @(negedge clk); req_valid = '0; flush = 1'b1; #1;
    chk("fp_hit_raw", cam_hit, 8'h01);
    @(negedge clk); flush = 1'b0; #1;
    chk("fp_reprobe", {done, upd, entry_valid}, {1'b0, 8'h00, 8'h00});
    @(negedge clk); #1;
    chk("fp_upd", upd, 8'h01);
    @(negedge clk);
    @(negedge clk); #1;
    chk("fp_done", {done, done_idx, done_dup}, {1'b1, 3'd0, 1'b0});

    // Reset asserted during WRITE.
    @(negedge clk);
    req_valid  = 2'b01;
    req_key[0] = 20'h55555;
    #1;
    chk("t6_ready", req_ready, 2'b01);
    @(negedge clk); req_valid = '0;
    @(negedge clk); #1;
    chk("t6_upd_write", upd, 8'h02);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_outs", {req_ready, upd, entry_valid, entry_busy, done, done_idx, done_dup}, '0);
    chk("t6_async_keys", {probe_key, upd_key}, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (done) seen_done++;
    end
    chk("t6_no_done", seen_done, 0);
    run_row('{2'b11, 20'h66666, 20'h77777, 2'b01, 1'b0, 3'd0}, "t6_first");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
